// File: rtl/uart_rx_demux4.sv
// 8N1 UART receiver that writes each good byte into one of four output slots
// in rotation, with per-byte, per-frame and framing-error strobes.
module uart_rx_demux4 #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] y0,
  output logic [7:0] y1,
  output logic [7:0] y2,
  output logic [7:0] y3,
  output logic [1:0] sel,
  output logic       byte_valid,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [1:0]    sel_reg;
  logic          byte_valid_reg, frame_done_reg, frame_err_reg;
  logic          timer_done;
  logic          stop_ok;

  assign timer_done = (timer_reg == BIT_LAST);
  // A good stop bit commits the assembled byte into the slot addressed by sel.
  assign stop_ok    = (state_reg == STOP) && timer_done && rx_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rxd;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'h00;
      sel_reg        <= 2'd0;
      byte_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            state_reg <= START;
            timer_reg <= '0;
          end
        end
        START: begin
          if (timer_reg == HALF_LAST) begin
            timer_reg   <= '0;
            bit_cnt_reg <= 3'd0;
            state_reg   <= rx_sync_reg ? IDLE : DATA;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        DATA: begin
          if (timer_done) begin
            timer_reg   <= '0;
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= STOP;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        STOP: begin
          if (timer_done) begin
            timer_reg <= '0;
            if (rx_sync_reg) begin
              byte_valid_reg <= 1'b1;
              frame_done_reg <= (sel_reg == 2'd3);
              sel_reg        <= sel_reg + 2'd1;
              state_reg      <= IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= BREAK;
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        BREAK: begin
          if (rx_sync_reg) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [7:0] slot_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_reg <= 8'h00;
      end else if (stop_ok && (sel_reg == 2'(gi))) begin
        slot_reg <= shift_reg;
      end
    end
  end

  assign y0         = g_slot[0].slot_reg;
  assign y1         = g_slot[1].slot_reg;
  assign y2         = g_slot[2].slot_reg;
  assign y3         = g_slot[3].slot_reg;
  assign sel        = sel_reg;
  assign byte_valid = byte_valid_reg;
  assign frame_done = frame_done_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_demux4.sv
// Bench for uart_rx_demux4: directed scenarios plus random bytes, checked
// against a slot/sel/pulse-count model of the receiver.
module tb_uart_rx_demux4;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] y0, y1, y2, y3;
  logic [1:0] sel;
  logic       byte_valid, frame_done, frame_err;

  uart_rx_demux4 #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .sel(sel), .byte_valid(byte_valid), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled on the falling edge.
  int cyc = 0;
  int bv_cnt = 0, fd_cnt = 0, fe_cnt = 0, bad_combo = 0;
  int last_bv_cyc = 0, start_cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (byte_valid) begin bv_cnt++; last_bv_cyc = cyc; end
    if (frame_done) fd_cnt++;
    if (frame_err) fe_cnt++;
    if ((frame_err && (byte_valid || frame_done)) || (frame_done && !byte_valid)) bad_combo++;
  end

  // Reference model
  logic [7:0] m_slot [4];
  int m_sel = 0, m_bv = 0, m_fd = 0, m_fe = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y0"}, 32'(y0), 32'(m_slot[0]));
    check({tag, ".y1"}, 32'(y1), 32'(m_slot[1]));
    check({tag, ".y2"}, 32'(y2), 32'(m_slot[2]));
    check({tag, ".y3"}, 32'(y3), 32'(m_slot[3]));
    check({tag, ".sel"}, 32'(sel), 32'(m_sel));
    check({tag, ".byte_valid_count"}, 32'(bv_cnt), 32'(m_bv));
    check({tag, ".frame_done_count"}, 32'(fd_cnt), 32'(m_fd));
    check({tag, ".frame_err_count"}, 32'(fe_cnt), 32'(m_fe));
    check({tag, ".pulse_overlap"}, 32'(bad_combo), 32'd0);
    $display("txn %s: y=%02h %02h %02h %02h sel=%0d bv=%0d fd=%0d fe=%0d",
             tag, y0, y1, y2, y3, sel, bv_cnt, fd_cnt, fe_cnt);
  endtask

  function automatic void model_byte(input logic [7:0] b, input logic stop);
    if (stop) begin
      m_slot[m_sel] = b;
      m_bv++;
      if (m_sel == 3) m_fd++;
      m_sel = (m_sel + 1) % 4;
    end else begin
      m_fe++;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    model_byte(b, stop);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, ".rst_y"}, {y0, y1, y2, y3}, 32'h0);
    check({tag, ".rst_ctl"}, {28'h0, sel, byte_valid, frame_done}, 32'h0);
    check({tag, ".rst_err"}, 32'(frame_err), 32'h0);
    for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;
    m_sel = 0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         lat2;
    for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.y", {y0, y1, y2, y3}, 32'h0);
    check("reset.ctl", {28'h0, sel, byte_valid, frame_done}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte, plus latency from the start-bit edge (edge sits half a cycle after start_cyc)
    send_byte(8'hA5, 1'b1);
    idle(4);
    check_all("a5");
    lat2 = 2 * (last_bv_cyc - start_cyc) - 1;
    checks++;
    assert (lat2 >= 2 * (19 * CPB / 2 + 2) && lat2 <= 2 * (19 * CPB / 2 + 3)) else begin
      errors++;
      $error("FAIL latency: observed %0d/2 cycles expected %0d..%0d", lat2, 19 * CPB / 2 + 2, 19 * CPB / 2 + 3);
    end

    // Four back-to-back bytes fill a frame
    do_reset("r4");
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(4);
    check_all("frame4");

    // Framing error then recovery
    send_byte(8'h3C, 1'b0);
    idle(10);
    check_all("ferr");
    send_byte(8'h5A, 1'b1);
    idle(4);
    check_all("after_ferr");

    // Short low glitch in IDLE
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    check_all("glitch");

    // Reset during data bit 4
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rxd = i[0];
      repeat ((i == 4) ? CPB / 2 : CPB) @(negedge clk);
    end
    do_reset("midrst");
    send_byte(8'hC3, 1'b1);
    idle(4);
    check_all("c3");

    // Five bytes wrap sel once
    do_reset("r5");
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    idle(4);
    check_all("five");

    // Random bytes with occasional bad stop bits and random gaps
    for (int n = 0; n < 10; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_byte(rb, rs);
      idle(rs ? $urandom_range(0, 8) : $urandom_range(4, 12));
      check_all($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
